// File: rtl/reset_requester.sv
// Reset request originator: merges software, debug and watchdog triggers into one
// registered active-low request, and keeps a sticky cause register that survives reset.
module reset_requester #(
  parameter int WDT_WIDTH   = 32,
  parameter int WARN_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sw_req,
  input  logic                 dbg_req,
  input  logic                 wdt_en,
  input  logic                 wdt_kick,
  input  logic [WDT_WIDTH-1:0] wdt_load,
  input  logic                 cause_clear,
  output logic                 rst_req_n,
  output logic                 wdt_warn,
  output logic [WDT_WIDTH-1:0] wdt_cnt,
  output logic [3:0]           cause
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [WDT_WIDTH-1:0] ZERO       = '0;
  localparam logic [WDT_WIDTH-1:0] ONE        = WDT_WIDTH'(1);
  localparam logic [WDT_WIDTH-1:0] WARN_LIMIT = WDT_WIDTH'(WARN_CYCLES);

  state_t     state;
  logic       expire;
  logic       trigger;
  logic [3:0] set_bits;

  // Configuration-time value: the cause register is never touched by rst.
  logic [3:0] cause_q = 4'b0001;

  // A kick on the last count wins over expiry; a count of 0 never expires.
  assign expire   = wdt_en && !wdt_kick && (wdt_cnt == ONE);
  assign trigger  = sw_req || dbg_req || expire;
  assign set_bits = {dbg_req, expire, sw_req, 1'b0};
  assign cause    = cause_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rst_req_n <= 1'b1;
      wdt_cnt   <= ZERO;
      wdt_warn  <= 1'b0;
    end else begin
      wdt_warn <= wdt_en && (wdt_cnt != ZERO) && (wdt_cnt <= WARN_LIMIT);

      if (!wdt_en || wdt_kick || (wdt_cnt == ZERO) || (wdt_cnt == ONE)) begin
        wdt_cnt <= wdt_load;
      end else begin
        wdt_cnt <= wdt_cnt - ONE;
      end

      // REQ is only left through rst, the reset generator's acknowledge.
      if ((state == IDLE) && trigger) begin
        state     <= REQ;
        rst_req_n <= 1'b0;
      end
    end
  end

  // Set wins over clear so a trigger in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cause_q <= (cause_clear ? 4'b0000 : cause_q) | set_bits;
    end
  end

endmodule

// File: tb/tb_reset_requester.sv
// Directed bench for reset_requester: a vector table for request/cause behaviour
// plus hand-written sequences for watchdog timing, kick boundary and reset masking.
module tb_reset_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw_req;
  logic        dbg_req;
  logic        wdt_en;
  logic        wdt_kick;
  logic [31:0] wdt_load;
  logic        cause_clear;
  logic        rst_req_n;
  logic        wdt_warn;
  logic [31:0] wdt_cnt;
  logic [3:0]  cause;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        sw;
    logic        dbg;
    logic        en;
    logic        kick;
    logic [31:0] load;
    logic        clr;
    logic        req_n;
    logic        warn;
    logic [31:0] cnt;
    logic [3:0]  cause;
  } vec_t;

  vec_t vecs[11];

  reset_requester #(.WDT_WIDTH(32), .WARN_CYCLES(1024)) dut (
    .clk(clk),
    .rst(rst),
    .sw_req(sw_req),
    .dbg_req(dbg_req),
    .wdt_en(wdt_en),
    .wdt_kick(wdt_kick),
    .wdt_load(wdt_load),
    .cause_clear(cause_clear),
    .rst_req_n(rst_req_n),
    .wdt_warn(wdt_warn),
    .wdt_cnt(wdt_cnt),
    .cause(cause)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic s, input logic d, input logic e,
                               input logic k, input logic [31:0] l, input logic c);
    rst = r; sw_req = s; dbg_req = d; wdt_en = e; wdt_kick = k; wdt_load = l; cause_clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic checkAll(input string name, input logic req_n, input logic warn,
                          input logic [31:0] cnt, input logic [3:0] cs);
    checkOutput({name, ".req_n"}, 32'(rst_req_n), 32'(req_n));
    checkOutput({name, ".warn"},  32'(wdt_warn),  32'(warn));
    checkOutput({name, ".cnt"},   wdt_cnt,        cnt);
    checkOutput({name, ".cause"}, 32'(cause),     32'(cs));
  endtask

  initial begin
    // rst sw dbg en kick load clr | req_n warn cnt cause
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0, 1'b1, 1'b0, 32'd0, 4'b0011};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0, 1'b1, 1'b0, 32'd0, 4'b0011};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0, 1'b1, 1'b0, 32'd5, 4'b0011};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0, 32'd5, 4'b0011};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0, 32'd5, 4'b0011};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0, 1'b1, 1'b0, 32'd0, 4'b0011};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 1'b1, 1'b1, 1'b0, 32'd5, 4'b0000};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0, 32'd5, 4'b1000};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 1'b0, 1'b1, 1'b0, 32'd0, 4'b1000};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 1'b1, 1'b0, 1'b0, 32'd5, 4'b1010};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0, 1'b1, 1'b0, 32'd0, 4'b1010};

    rst = 1'b1; sw_req = 1'b0; dbg_req = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0;
    wdt_load = 32'd5; cause_clear = 1'b0;
    #1;
    checkOutput("cause_config", 32'(cause), 32'h1);

    // Initial reset
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0);
    checkAll("reset", 1'b1, 1'b0, 32'd0, 4'b0001);

    // Software request, held until acknowledged by rst
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0);
    checkOutput("sw_pre_req_n", 32'(rst_req_n), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0);
    checkOutput("sw_req_n", 32'(rst_req_n), 32'h0);
    checkOutput("sw_cause", 32'(cause), 32'h3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0);
      checkOutput("sw_hold_req_n", 32'(rst_req_n), 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0);
      checkOutput("sw_ack_req_n", 32'(rst_req_n), 32'h1);
    end
    checkOutput("sw_ack_cause", 32'(cause), 32'h3);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].sw, vecs[i].dbg, vecs[i].en, vecs[i].kick,
                    vecs[i].load, vecs[i].clr);
      checkAll($sformatf("vec%0d", i), vecs[i].req_n, vecs[i].warn, vecs[i].cnt, vecs[i].cause);
    end

    // Watchdog expiry with load 5, then a second expiry inside REQ
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 1'b1);
    checkAll("wdt_load", 1'b1, 1'b0, 32'd5, 4'b0000);
    for (int c = 4; c >= 1; c--) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 1'b0);
      checkAll($sformatf("wdt_cnt%0d", c), 1'b1, 1'b1, 32'(c), 4'b0000);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 1'b0);
    checkAll("wdt_expire", 1'b0, 1'b1, 32'd5, 4'b0100);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 1'b0);
    checkAll("wdt_expire2", 1'b0, 1'b1, 32'd5, 4'b0100);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 1'b0);
    checkAll("mid_req_rst", 1'b1, 1'b0, 32'd0, 4'b0100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 1'b0);
    checkAll("no_replay", 1'b1, 1'b0, 32'd5, 4'b0100);

    // Kick in the cycle where the count is 1
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3, 1'b1);
    checkAll("kick_load", 1'b1, 1'b0, 32'd3, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3, 1'b0);
    checkOutput("kick_pre_cnt", wdt_cnt, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0);
    checkAll("kick_last", 1'b1, 1'b1, 32'd3, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3, 1'b0);
    checkOutput("kick_after_cnt", wdt_cnt, 32'd2);

    // Early-warning threshold at 1024, and disable
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1025, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1025, 1'b0);
    checkAll("warn_load", 1'b1, 1'b0, 32'd1025, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1025, 1'b0);
    checkAll("warn_1025", 1'b1, 1'b0, 32'd1024, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1025, 1'b0);
    checkAll("warn_1024", 1'b1, 1'b1, 32'd1023, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1025, 1'b0);
    checkAll("warn_disabled", 1'b1, 1'b0, 32'd1025, 4'b0000);

    // Requests ignored while rst is high
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd5, 1'b0);
      checkOutput("rst_mask_req_n", 32'(rst_req_n), 32'h1);
      checkOutput("rst_mask_cause", 32'(cause), 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 1'b0);
    checkAll("rst_mask_after", 1'b1, 1'b0, 32'd5, 4'b0000);

    // Zero load never expires
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      checkOutput("zero_load_req_n", 32'(rst_req_n), 32'h1);
      checkOutput("zero_load_cnt", wdt_cnt, 32'd0);
      checkOutput("zero_load_warn", 32'(wdt_warn), 32'h0);
    end
    checkOutput("zero_load_cause", 32'(cause), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
